// File: rtl/l2_mem_write_buffer_pkg.sv
// rtl/l2_mem_write_buffer_pkg.sv - shared widths, default depth and FSM states for the L2 write buffer
package l2_mem_write_buffer_pkg;
    localparam int LINE_W        = 128;
    localparam int LADDR_W       = 28;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {IDLE, MEM_WR, MEM_RD, RESP} state_t;
endpackage

// File: rtl/l2_mem_write_buffer_wb_fifo.sv
// rtl/l2_mem_write_buffer_wb_fifo.sv - circular write-back line store with address match for hits and coalescing
module wb_fifo
    import l2_mem_write_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LADDR_W-1:0]     lk_addr,
    input  logic                   wr_en,
    input  logic [LINE_W-1:0]      wr_data,
    input  logic                   head_busy,
    input  logic                   pop,
    output logic                   wr_ok,
    output logic                   rd_hit,
    output logic [LINE_W-1:0]      rd_data,
    output logic [LADDR_W-1:0]     head_addr,
    output logic [LINE_W-1:0]      head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [LADDR_W-1:0] addr_q [DEPTH];
    logic [LINE_W-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [PTR_W-1:0]   head, tail, idx, co_idx;
    logic               co_hit, not_full, do_push, do_coal;

    // Scan oldest to youngest so the youngest match wins; the in-flight head is never a coalesce target.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        co_hit  = 1'b0;
        co_idx  = head;
        idx     = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && addr_q[idx] == lk_addr) begin
                rd_hit  = 1'b1;
                rd_data = data_q[idx];
                if (!(head_busy && idx == head)) begin
                    co_hit = 1'b1;
                    co_idx = idx;
                end
            end
        end
    end

    assign not_full  = (count != FULL_CNT);
    assign wr_ok     = co_hit || not_full;
    assign do_push   = wr_en && !co_hit && not_full;
    assign do_coal   = wr_en && co_hit;
    assign head_addr = addr_q[head];
    assign head_data = data_q[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            if (do_push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            case ({do_push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[tail] <= lk_addr;
            data_q[tail] <= wr_data;
        end else if (do_coal) begin
            data_q[co_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/l2_mem_write_buffer.sv
// rtl/l2_mem_write_buffer.sv - L2 line write buffer: upstream hit/push service, read-miss and drain FSM
module l2_mem_write_buffer
    import l2_mem_write_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up_read,
    input  logic               up_write,
    input  logic [LADDR_W-1:0] up_addr,
    input  logic [LINE_W-1:0]  up_wdata,
    output logic [LINE_W-1:0]  up_rdata,
    output logic               up_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic [LADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]  mem_wdata,
    input  logic [LINE_W-1:0]  mem_rdata,
    input  logic               mem_ready,
    output logic               wb_empty
);
    state_t                 state, state_nxt;
    logic [$clog2(DEPTH):0] count;
    logic                   rd_req, svc, wr_en, wr_ok, wr_go, rd_hit, rd_hit_go, rd_miss;
    logic                   has_entries, drain_go, head_busy, pop;
    logic [LINE_W-1:0]      rd_data, head_data;
    logic [LADDR_W-1:0]     head_addr;

    // A request stays asserted through its up_ready cycle; it must not be taken a second time.
    assign svc         = !up_ready && state != RESP;
    assign rd_req      = up_read && !up_write;
    assign wr_en       = svc && up_write;
    assign wr_go       = wr_en && wr_ok;
    assign rd_hit_go   = svc && rd_req && rd_hit;
    assign rd_miss     = svc && rd_req && !rd_hit;
    assign has_entries = (count != '0);
    assign drain_go    = state == IDLE && has_entries && !rd_miss;
    // Head is being launched or is on the bus; writes never coincide with reads so read priority is moot here.
    assign head_busy   = state == MEM_WR || (state == IDLE && has_entries);
    assign pop         = state == MEM_WR && mem_ready;
    assign wb_empty    = !has_entries && state != MEM_WR;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .lk_addr   (up_addr),
        .wr_en     (wr_en),
        .wr_data   (up_wdata),
        .head_busy (head_busy),
        .pop       (pop),
        .wr_ok     (wr_ok),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_miss)       state_nxt = MEM_RD;
                else if (drain_go) state_nxt = MEM_WR;
            end
            MEM_WR:  if (mem_ready) state_nxt = IDLE;
            MEM_RD:  if (mem_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_ready  <= 1'b0;
            up_rdata  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            up_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_miss) begin
                        mem_read <= 1'b1;
                        mem_addr <= up_addr;
                    end else if (drain_go) begin
                        mem_write <= 1'b1;
                        mem_addr  <= head_addr;
                        mem_wdata <= head_data;
                    end
                end
                MEM_WR: if (mem_ready) mem_write <= 1'b0;
                MEM_RD: begin
                    if (mem_ready) begin
                        mem_read <= 1'b0;
                        up_rdata <= mem_rdata;
                        up_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (wr_go) up_ready <= 1'b1;
            if (rd_hit_go) begin
                up_ready <= 1'b1;
                up_rdata <= rd_data;
            end
        end
    end
endmodule

// File: tb/tb_l2_mem_write_buffer.sv
// tb/tb_l2_mem_write_buffer.sv - directed self-checking bench for l2_mem_write_buffer
module tb_l2_mem_write_buffer;
    localparam logic [127:0] RPAT = 128'hFEED_0001_FEED_0002_FEED_0003_FEED_0004;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         up_read = 1'b0, up_write = 1'b0;
    logic [27:0]  up_addr = '0;
    logic [127:0] up_wdata = '0;
    logic [127:0] up_rdata;
    logic         up_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic         wb_empty;

    int n_tests = 0, n_fail = 0;
    int cyc_n = 0;
    int mem_hold = 0, mem_lat = 1, wait_cnt = 0;
    int both_cnt = 0, rd_seen = 0;
    int rd_first_cyc = -1, rd_ready_cyc = -1, wr_done_cyc = -1;
    logic [27:0]  wq_addr [$];
    logic [127:0] wq_data [$];

    l2_mem_write_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_read   (up_read),
        .up_write  (up_write),
        .up_addr   (up_addr),
        .up_wdata  (up_wdata),
        .up_rdata  (up_rdata),
        .up_ready  (up_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .wb_empty  (wb_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    // Slow memory: answers mem_lat cycles after a request is seen, unless held.
    initial forever begin
        @(negedge clk);
        mem_ready = 1'b0;
        if (mem_read && mem_write) both_cnt++;
        if (mem_read) begin
            rd_seen++;
            if (rd_first_cyc < 0) rd_first_cyc = cyc_n;
        end
        if ((mem_read || mem_write) && mem_hold == 0) begin
            if (wait_cnt >= mem_lat) begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
                if (mem_write) begin
                    wq_addr.push_back(mem_addr);
                    wq_data.push_back(mem_wdata);
                    wr_done_cyc = cyc_n;
                end else begin
                    mem_rdata    = RPAT;
                    rd_ready_cyc = cyc_n;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] dpat(input int i);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(i);
        return {4{w}};
    endfunction

    task automatic do_write(input logic [27:0] a, input logic [127:0] d, output int lat);
        up_addr = a; up_wdata = d; up_write = 1'b1; lat = 0;
        do begin @(negedge clk); lat++; end while (!up_ready && lat < 300);
        up_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [27:0] a, output logic [127:0] d, output int lat, output int seen);
        up_addr = a; up_read = 1'b1; lat = 0;
        do begin @(negedge clk); lat++; end while (!up_ready && lat < 300);
        d = up_rdata; seen = cyc_n;
        up_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (!wb_empty && n < 500) begin @(negedge clk); n++; end
        check(tag, wb_empty, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, seen, n, saw;
        logic [127:0] rd;

        repeat (3) @(negedge clk);
        check("rst_up_ready", up_ready, 1'b0);
        check("rst_up_rdata", up_rdata, '0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_wb_empty", wb_empty, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // single write then drain
        do_write(28'h0000010, {16{8'h11}}, lat);
        check("wr_lat", lat, 1);
        wait_empty("wr_drain_empty");
        check("wr_drain_cnt", wq_addr.size(), 1);
        check("wr_drain_addr", wq_addr[0], 28'h0000010);
        check("wr_drain_data", wq_data[0], {16{8'h11}});
        wq_addr.delete(); wq_data.delete();

        // coalesce into a waiting entry, but never into the in-flight head
        mem_hold = 1;
        do_write(28'h50, dpat(50), lat);
        do_write(28'h20, dpat(1), lat);
        do_write(28'h20, dpat(2), lat);
        check("coal_lat", lat, 1);
        do_write(28'h50, dpat(51), lat);
        mem_hold = 0;
        wait_empty("coal_empty");
        check("coal_cnt", wq_addr.size(), 3);
        check("coal_a0", wq_addr[0], 28'h50);
        check("coal_d0", wq_data[0], dpat(50));
        check("coal_a1", wq_addr[1], 28'h20);
        check("coal_d1", wq_data[1], dpat(2));
        check("coal_a2", wq_addr[2], 28'h50);
        check("coal_d2", wq_data[2], dpat(51));
        wq_addr.delete(); wq_data.delete();

        // full stall: fifth write waits for the first pop
        mem_hold = 1;
        for (int i = 0; i < 4; i++) begin
            do_write(28'h100 + 28'(i), dpat(100 + i), lat);
            check($sformatf("full_lat%0d", i), lat, 1);
        end
        up_addr = 28'h104; up_wdata = dpat(104); up_write = 1'b1;
        saw = 0;
        repeat (6) begin @(negedge clk); if (up_ready) saw = 1; end
        check("full_stall", saw, 0);
        mem_hold = 0;
        n = 0;
        while (!up_ready && n < 300) begin @(negedge clk); n++; end
        check("full_accept", up_ready, 1'b1);
        check("full_accept_after_pop", wq_addr.size(), 1);
        up_write = 1'b0;
        @(negedge clk);
        wait_empty("full_empty");
        check("full_cnt", wq_addr.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("full_a%0d", i), wq_addr[i], 28'h100 + 28'(i));
            check($sformatf("full_d%0d", i), wq_data[i], dpat(100 + i));
        end
        wq_addr.delete(); wq_data.delete();

        // read hits return the youngest match, no memory read
        mem_hold = 1; rd_seen = 0;
        do_write(28'h30, {16{8'hAB}}, lat);
        do_read(28'h30, rd, lat, seen);
        check("hit_lat", lat, 1);
        check("hit_data", rd, {16{8'hAB}});
        do_write(28'h30, {16{8'hCD}}, lat);
        do_read(28'h30, rd, lat, seen);
        check("hit_young_data", rd, {16{8'hCD}});
        check("hit_no_mem_read", rd_seen, 0);
        mem_hold = 0;
        wait_empty("hit_empty");
        check("hit_cnt", wq_addr.size(), 2);
        check("hit_d1", wq_data[1], {16{8'hCD}});
        wq_addr.delete(); wq_data.delete();

        // read miss waits for the in-flight drain
        mem_hold = 1; rd_first_cyc = -1;
        do_write(28'h80, dpat(80), lat);
        up_addr = 28'h40; up_read = 1'b1;
        repeat (4) @(negedge clk);
        check("miss_wait", mem_read, 1'b0);
        mem_hold = 0;
        n = 0;
        while (!up_ready && n < 300) begin @(negedge clk); n++; end
        rd = up_rdata; seen = cyc_n;
        up_read = 1'b0;
        @(negedge clk);
        check("miss_data", rd, RPAT);
        check("miss_after_wr", rd_first_cyc > wr_done_cyc, 1'b1);
        check("miss_resp_lat", seen, rd_ready_cyc + 1);
        wait_empty("miss_empty");
        check("miss_wr_cnt", wq_addr.size(), 1);
        wq_addr.delete(); wq_data.delete();

        // asynchronous reset mid-drain discards the buffer
        mem_hold = 1;
        for (int i = 0; i < 3; i++) do_write(28'h200 + 28'(i), dpat(200 + i), lat);
        check("rst_pre_mem_write", mem_write, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_mem_write", mem_write, 1'b0);
        check("rst_async_wb_empty", wb_empty, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; mem_hold = 0;
        repeat (20) @(negedge clk);
        check("rst_no_writes", wq_addr.size(), 0);
        do_write(28'h300, dpat(300), lat);
        check("rst_post_lat", lat, 1);
        wait_empty("rst_post_empty");
        check("rst_post_cnt", wq_addr.size(), 1);
        check("rst_post_addr", wq_addr[0], 28'h300);

        check("mem_rd_wr_exclusive", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/l2_mem_write_buffer.md
L2_MEM_WRITE_BUFFER -- requirements
Module: l2_mem_write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of 128-bit line write-back entries (power of two, >=2).
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- up_read  input  1  line read request from L2 D-cache, held until up_ready.
- up_write  input  1  line write-back request from L2 D-cache, held until up_ready.
- up_addr  input  28  line address [31:4].
- up_wdata  input  128  write-back line data.
- up_rdata  output  128  read line data, valid while up_ready=1.
- up_ready  output  1  one-cycle completion pulse to L2.
- mem_read  output  1  read request to slow memory, held until mem_ready.
- mem_write  output  1  write request to slow memory, held until mem_ready.
- mem_addr  output  28  line address [31:4] to slow memory.
- mem_wdata  output  128  write data to slow memory.
- mem_rdata  input  128  slow-memory read data, valid with mem_ready.
- mem_ready  input  1  slow-memory completion pulse.
- wb_empty  output  1  high when no entry is buffered and no memory write is in flight.

Function
REQ-003 The block SHALL hold DEPTH entries {valid, addr[27:0], data[127:0]} in a circular FIFO (head/tail pointers, count 0..DEPTH).
REQ-004 Upstream write, not full, no match: entry SHALL be pushed at tail; up_ready SHALL pulse exactly one cycle after the request is first sampled.
REQ-005 Upstream write whose addr matches a valid non-in-flight entry SHALL overwrite that entry's data (coalesce), count unchanged, same one-cycle latency.
REQ-006 A write matching only the in-flight head entry SHALL NOT coalesce into it; it SHALL be pushed as a new entry.
REQ-007 Upstream write with count==DEPTH and no coalesce target SHALL stall (up_ready low) until count<DEPTH; fullness uses the registered count, so a pop and a push never occur in the same cycle at full.
REQ-008 Upstream read hitting a buffered entry SHALL return the youngest matching entry's data on up_rdata with up_ready one cycle later; no memory access occurs.
REQ-009 Upstream read miss SHALL wait for any in-flight memory write to complete (no abort), then assert mem_read; up_ready SHALL pulse the cycle after mem_ready, with up_rdata registered from mem_rdata.
REQ-010 Drain: when in IDLE, count>0, and no upstream read miss pending, the head entry SHALL be issued with mem_write=1, mem_addr/mem_wdata from head, held stable until mem_ready; head SHALL then pop.
REQ-011 Read misses SHALL have priority over drain when both are eligible in IDLE.
REQ-012 mem_read and mem_write SHALL never be high together; mem_addr/mem_wdata SHALL be stable while either is high.
REQ-013 FSM states: IDLE, MEM_WR (drain in flight), MEM_RD (read miss in flight), RESP (one-cycle up_ready). Transitions: IDLE->MEM_RD on read miss; IDLE->MEM_WR on drain; MEM_WR->IDLE on mem_ready; MEM_RD->RESP on mem_ready; RESP->IDLE unconditionally.
REQ-014 Buffer hits/pushes (REQ-004/005/008) SHALL be serviced in any state except RESP, in parallel with an in-flight drain.
REQ-015 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-016 up_read and up_write asserted together is illegal; the block SHALL treat it as a write.
REQ-017 wb_empty SHALL be combinational from count==0 and state!=MEM_WR.

Reset
REQ-018 On rst_n low (asynchronous, any time incl. mid-transfer): state=IDLE, count=0, all valid=0, up_ready=0, up_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, wb_empty=1; buffered data is discarded.
REQ-019 After rst_n rises, the first request SHALL be sampled on the next rising edge.

Structure
REQ-020 A shared package SHALL hold LINE_W=128, LADDR_W=28, default DEPTH, and the FSM state enum.
REQ-021 The FIFO storage plus address-match (CAM) logic SHALL be sub-module wb_fifo; the FSM and port muxing live in l2_mem_write_buffer.

Verification
REQ-022 Write A=0x0000010 D=0x11..11 -> up_ready at +1 cycle; then mem_write with addr 0x0000010, data 0x11..11 until mem_ready; wb_empty returns to 1.
REQ-023 Five writes (DEPTH=4), mem_ready withheld -> fifth stalls until first drain's mem_ready, then accepted; memory sees all five in order.
REQ-024 Write A=0x20 D1, write A=0x20 D2 before drain -> count=1, memory receives only D2.
REQ-025 Write A=0x30 D=0xAB.., then read A=0x30 -> up_rdata=0xAB.. at +1 cycle, mem_read never asserted.
REQ-026 Drain in flight, read miss A=0x40 -> mem_read asserts only after the drain's mem_ready; up_ready one cycle after read mem_ready with mem_rdata.
REQ-027 rst_n low during MEM_WR with 3 entries -> mem_write drops immediately, wb_empty=1, no further memory writes after release.
